// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: forward-select codes,
// default register address width and performance counter width.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int REG_AW_DEF = 5;
    localparam int PERF_W     = 32;

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard and busy flag for the single long-latency mul/div unit.
// Lookups treat a bit being cleared this cycle as already free, so Decode can issue with the W bypass.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [REG_AW-1:0] start_rd,
    input  logic              done,
    input  logic [REG_AW-1:0] done_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    output logic              rs1_pend,
    output logic              rs2_pend,
    output logic              rd_pend,
    output logic              busy
);

    localparam int NREG = 1 << REG_AW;

    logic [NREG-1:0] sb;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] sb_next;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (start && start_rd != '0) set_vec = NREG'(1) << start_rd;
        if (done)                    clr_vec = NREG'(1) << done_rd;
        // set is applied after clear so a same-cycle set/clear of one bit leaves it set
        sb_next    = (sb & ~clr_vec) | set_vec;
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb   <= '0;
            busy <= 1'b0;
        end else begin
            sb <= sb_next;
            if (start)     busy <= 1'b1;
            else if (done) busy <= 1'b0;
        end
    end

    assign rs1_pend = sb[rs1] & ~(done && done_rd == rs1);
    assign rs2_pend = sb[rs2] & ~(done && done_rd == rs2);
    assign rd_pend  = sb[rd]  & ~(done && done_rd == rd);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage core: forwarding, multi-cycle load-use stall,
// mul/div scoreboard stall and branch flush. HAZARD_PERF_CNT_EN adds stall/flush counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int LU_STALL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [REG_AW-1:0] RD_M,
    input  logic [REG_AW-1:0] RD_W,
    input  logic [REG_AW-1:0] Rs1_D,
    input  logic [REG_AW-1:0] Rs2_D,
    input  logic [REG_AW-1:0] Rs1_E,
    input  logic [REG_AW-1:0] Rs2_E,
    input  logic [REG_AW-1:0] RD_D,
    input  logic              RegWriteD,
    input  logic              ResultSrcE0,
    input  logic              PCSrcE,
    input  logic              MdOpD,
    input  logic              MdStartE,
    input  logic              MdDoneW,
    input  logic [REG_AW-1:0] MdRdW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
`ifdef HAZARD_PERF_CNT_EN
    output logic [PERF_W-1:0] PerfStallCnt,
    output logic [PERF_W-1:0] PerfFlushCnt,
`endif
    output logic              MdBusy
);

    logic [1:0] lu_cnt;
    logic       lu;
    logic       lus;
    logic       sbs;
    logic       hazard;
    logic       rs1_pend;
    logic       rs2_pend;
    logic       rd_pend;
    logic       md_busy;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                           input logic wm, input logic [REG_AW-1:0] rdm,
                                           input logic ww, input logic [REG_AW-1:0] rdw);
        if (rs == '0)                fwd_sel = FWD_RF;
        else if (wm && rdm == rs)    fwd_sel = FWD_MEM;
        else if (ww && rdw == rs)    fwd_sel = FWD_WB;
        else                         fwd_sel = FWD_RF;
    endfunction

    hazard_scoreboard #(.REG_AW(REG_AW)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .start    (MdStartE),
        .start_rd (RD_E),
        .done     (MdDoneW),
        .done_rd  (MdRdW),
        .rs1      (Rs1_D),
        .rs2      (Rs2_D),
        .rd       (RD_D),
        .rs1_pend (rs1_pend),
        .rs2_pend (rs2_pend),
        .rd_pend  (rd_pend),
        .busy     (md_busy)
    );

    assign lu     = ResultSrcE0 && RD_E != '0 && (RD_E == Rs1_D || RD_E == Rs2_D);
    assign lus    = lu || lu_cnt != 2'd0;
    assign sbs    = rs1_pend || rs2_pend || (RegWriteD && rd_pend) || (MdOpD && md_busy);
    assign hazard = lus || sbs;

    // lu_cnt covers the stall cycles after the first, when the load has left Execute
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         lu_cnt <= 2'd0;
        else if (PCSrcE)                 lu_cnt <= 2'd0;
        else if (lu && lu_cnt == 2'd0)   lu_cnt <= 2'(LU_STALL - 1);
        else if (lu_cnt != 2'd0)         lu_cnt <= lu_cnt - 2'd1;
    end

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        MdBusy    = 1'b0;
        if (!rst) begin
            ForwardAE = fwd_sel(Rs1_E, RegWriteM, RD_M, RegWriteW, RD_W);
            ForwardBE = fwd_sel(Rs2_E, RegWriteM, RD_M, RegWriteW, RD_W);
            // a mul/div result retiring in W is bypassed to Decode like any W write
            ForwardAD = Rs1_D != '0 && ((RegWriteW && RD_W == Rs1_D) || (MdDoneW && MdRdW == Rs1_D));
            ForwardBD = Rs2_D != '0 && ((RegWriteW && RD_W == Rs2_D) || (MdDoneW && MdRdW == Rs2_D));
            StallF    = hazard && !PCSrcE;
            StallD    = hazard && !PCSrcE;
            FlushD    = PCSrcE;
            FlushE    = hazard || PCSrcE;
            MdBusy    = md_busy;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PerfStallCnt <= '0;
            PerfFlushCnt <= '0;
        end else begin
            if (StallD && PerfStallCnt != '1) PerfStallCnt <= PerfStallCnt + 1'b1;
            if (FlushD && PerfFlushCnt != '1) PerfFlushCnt <= PerfFlushCnt + 1'b1;
        end
    end
`endif

endmodule
